// File: rtl/stack_mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with fixed read latency.
// One transaction at a time: IDLE -> CMD -> (WAIT) -> DONE -> IDLE.
// Round-robin on ties, with the first tie after reset going to requester 0.
module stack_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_ack,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m1_ack,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {IDLE, CMD, WAIT, DONE} state_t;

  // Last WAIT cycle index; WAIT is skipped entirely when RD_LAT is 1.
  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t                state, next_state;
  logic                  lat_we;
  logic [1:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;
  logic                  take, pick;
  logic                  done_rd;

  // Arbitration: decide whether IDLE starts a transaction and for whom.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    take = 1'b0;
    pick = grant;
    if (m0_req && m1_req) begin
      take = 1'b1;
      pick = ~grant;
    end else if (m0_req) begin
      take = 1'b1;
      pick = 1'b0;
    end else if (m1_req) begin
      take = 1'b1;
      pick = 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (take) next_state = CMD;
      CMD:  next_state = (RD_LAT > 1) ? WAIT : DONE;
      WAIT: if (wait_cnt == WAIT_LAST) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Command latch, wait counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b1;
      lat_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      wait_cnt   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      if (state == IDLE && take) begin
        grant     <= pick;
        lat_we    <= pick ? m1_we    : m0_we;
        ram_addr  <= pick ? m1_addr  : m0_addr;
        ram_wdata <= pick ? m1_wdata : m0_wdata;
      end
      if (state == CMD)       wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;
      if (done_rd && !grant)  m0_rdata_q <= ram_rdata;
      if (done_rd && grant)   m1_rdata_q <= ram_rdata;
    end
  end

  // Outputs: rdata bypasses the capture register in the ack cycle so it is
  // already valid when ack is seen, then holds until the next ack.
  always_comb begin
    done_rd  = (state == DONE) && !lat_we;
    busy     = (state != IDLE);
    ram_we   = (state == CMD) && lat_we;
    m0_ack   = (state == DONE) && !grant;
    m1_ack   = (state == DONE) && grant;
    m0_rdata = (done_rd && !grant) ? ram_rdata : m0_rdata_q;
    m1_rdata = (done_rd && grant)  ? ram_rdata : m1_rdata_q;
  end

endmodule

// File: doc/stack_mem_arbiter.md
STACK_MEM_ARBITER -- requirements
Module: stack_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, RAM word address width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1, RAM read latency in cycles from command to valid ram_rdata; legal range 1..4.
REQ-004 SHALL have one clock and a synchronous, active-high reset; clk and reset are named as below.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 m0_req, m1_req  input  1 each  access request from requester 0 (executer) and requester 1 (loader/debug).
REQ-008 m0_we, m1_we  input  1 each  1 = write, 0 = read; valid while the matching req is high.
REQ-009 m0_addr, m1_addr  input  ADDR_WIDTH each  word address.
REQ-010 m0_wdata, m1_wdata  input  DATA_WIDTH each  write data.
REQ-011 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-012 m0_rdata, m1_rdata  output  DATA_WIDTH each  read data; valid in the ack cycle and held until the next ack to that requester.
REQ-013 ram_addr  output  ADDR_WIDTH  RAM address.
REQ-014 ram_wdata  output  DATA_WIDTH  RAM write data.
REQ-015 ram_we  output  1  RAM write strobe.
REQ-016 ram_rdata  input  DATA_WIDTH  RAM read data.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 grant  output  1  index of the requester currently or most recently served.

Function
REQ-019 The FSM SHALL have states IDLE, CMD, WAIT, DONE.
REQ-020 In IDLE with no req high, the FSM SHALL stay in IDLE with all RAM outputs held and ram_we=0.
REQ-021 In IDLE with exactly one req high, the FSM SHALL grant that requester and latch its we, addr and wdata into internal registers.
REQ-022 In IDLE with both reqs high, the FSM SHALL grant the requester other than grant (round-robin); after reset the first tie goes to requester 0.
REQ-023 After a grant, the FSM SHALL move to CMD.
REQ-024 In CMD, the block SHALL drive ram_addr and ram_wdata from the latched values, and drive ram_we = latched we for exactly that one cycle.
REQ-025 From CMD, the FSM SHALL move to WAIT when RD_LAT>1, and to DONE otherwise.
REQ-026 WAIT SHALL last RD_LAT-1 cycles, counted by an internal counter.
REQ-027 In DONE, for a read, the block SHALL capture ram_rdata into the granted requester's rdata register.
REQ-028 In DONE, the block SHALL pulse that requester's ack for one cycle; writes and reads share the same timing.
REQ-029 From DONE, the FSM SHALL always return to IDLE.
REQ-030 Latency: with req first seen in IDLE at cycle T, CMD SHALL be at T+1 and ack at T+1+RD_LAT.
REQ-031 A requester keeps req and its command inputs stable until ack; changes to them after the grant SHALL NOT affect the transaction in flight.
REQ-032 A req that is high in the cycle after ack SHALL be treated as a new request; back-to-back requests are legal.
REQ-033 A req from the non-granted requester during CMD, WAIT or DONE SHALL be held pending and arbitrated in the next IDLE cycle; it SHALL never be dropped.
REQ-034 m0_ack and m1_ack SHALL never be high in the same cycle.
REQ-035 ram_we SHALL never be high outside CMD.
REQ-036 A write followed by a read to the same address SHALL return the written data, since transactions never overlap.

Reset
REQ-037 On reset, the FSM SHALL go to IDLE.
REQ-038 On reset, busy, ram_we, m0_ack and m1_ack SHALL be 0.
REQ-039 On reset, grant SHALL be 1, so the first tie goes to requester 0.
REQ-040 On reset, ram_addr, ram_wdata, m0_rdata, m1_rdata and the wait counter SHALL be 0.
REQ-041 A reset mid-transaction SHALL abort it with no ack issued and no further ram_we; a write already strobed in CMD is not undone.
REQ-042 Requests still high after reset deasserts SHALL be arbitrated as new requests.

Verification
REQ-043 RD_LAT=1, m0 write addr 0x004 data 0x0000_00AB at T -> ram_we=1 at T+1 only, m0_ack at T+2, busy high T+1..T+2.
REQ-044 RD_LAT=1, m1 read addr 0x004 after REQ-043 -> m1_ack at T+2 with m1_rdata=0x0000_00AB, held after ack.
REQ-045 Both reqs high from reset release, each doing 3 back-to-back reads -> grants alternate 0,1,0,1,0,1 and no ack is lost or duplicated.
REQ-046 RD_LAT=3, m0 read addr 0x010 -> CMD at T+1, WAIT at T+2..T+3, m0_ack at T+4.
REQ-047 reset asserted in the WAIT cycle of an m1 read -> no m1_ack; next cycle IDLE with busy=0 and grant=1.
REQ-048 m1 req rises during m0's CMD cycle -> m1 granted in the first IDLE after m0_ack, CMD one cycle later.
